// File: rtl/picomips_io_pkg.sv
// Shared types and constants for the picoMIPS switch/LED I/O sequencer.
package picomips_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    CAPTURE,
    WAIT_RELEASE
  } io_state_t;

  localparam int SW_W       = 10;
  localparam int DATA_W     = 8;
  localparam int STROBE_BIT = 8;
  localparam int RUN_BIT    = 9;

endpackage

// File: rtl/sw_debouncer.sv
// Two-flop synchroniser on all switch bits plus a stable-count debouncer on the strobe bit.
module sw_debouncer
  import picomips_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SW_W-1:0] i_sw,
  output logic [SW_W-1:0] o_s,
  output logic            o_db
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0] r_sync1;
  logic [SW_W-1:0] r_sync2;
  logic            r_db;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      // Level only follows the strobe after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (r_sync2[STROBE_BIT] != r_db) begin
        if (r_cnt == CNT_LAST) begin
          r_db  <= r_sync2[STROBE_BIT];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_s  = r_sync2;
  assign o_db = r_db;

endmodule

// File: rtl/sw_io_sequencer.sv
// Serves core byte reads from the slide switches (one byte per strobe press/release)
// and registers core output bytes onto the LEDs.
module sw_io_sequencer
  import picomips_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SW_W-1:0]   SW,
  input  logic              cpu_rd_req,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_rd_valid,
  output logic              cpu_stall,
  input  logic              cpu_wr_en,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_run,
  output logic [DATA_W-1:0] LED
);

  logic [SW_W-1:0]   w_s;
  logic              w_db;
  logic              w_capture;
  logic              w_unused_strobe;
  io_state_t         r_state;
  io_state_t         w_state_next;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_led;

  sw_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_debouncer (
    .clk  (clk),
    .reset(reset),
    .i_sw (SW),
    .o_s  (w_s),
    .o_db (w_db)
  );

  // The raw synchronised strobe is only meaningful through the debounced level.
  assign w_unused_strobe = w_s[STROBE_BIT];

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu_rd_req) w_state_next = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        // A withdrawn request abandons the read even if a press is pending.
        if (!cpu_rd_req) begin
          w_state_next = IDLE;
        end else if (w_db) begin
          w_state_next = CAPTURE;
          w_capture    = 1'b1;
        end
      end
      CAPTURE:      w_state_next = WAIT_RELEASE;
      WAIT_RELEASE: begin
        if (!w_db) w_state_next = IDLE;
      end
      default:      w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_rd_data <= '0;
      r_led     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) r_rd_data <= w_s[DATA_W-1:0];
      if (cpu_wr_en) r_led <= cpu_wr_data;
    end
  end

  assign cpu_rd_valid = (r_state == CAPTURE);
  assign cpu_stall    = cpu_rd_req & ~cpu_rd_valid;
  assign cpu_rd_data  = r_rd_data;
  assign cpu_run      = w_s[RUN_BIT];
  assign LED          = r_led;

endmodule

// File: tb/tb_sw_io_sequencer.sv
// Self-checking bench for sw_io_sequencer: vector table, directed corner cases and a
// randomized run against a behavioural model.
module tb_sw_io_sequencer;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] sw;
  logic       rd_req;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] cpu_rd_data;
  logic       cpu_rd_valid;
  logic       cpu_stall;
  logic       cpu_run;
  logic [7:0] led;

  always #5 clk = ~clk;

  sw_io_sequencer #(
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .SW          (sw),
    .cpu_rd_req  (rd_req),
    .cpu_rd_data (cpu_rd_data),
    .cpu_rd_valid(cpu_rd_valid),
    .cpu_stall   (cpu_stall),
    .cpu_wr_en   (wr_en),
    .cpu_wr_data (wr_data),
    .cpu_run     (cpu_run),
    .LED         (led)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: switch samples two edges old, strobe level flips after N
  // consecutive disagreeing samples, read service tracked as waiting/deliver/hold flags.
  logic [9:0] m_s1, m_s;
  logic       m_db;
  logic       m_hist[N];
  logic       m_waiting, m_deliver, m_hold;
  logic [7:0] m_data, m_led;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s = '0; m_db = 1'b0;
    for (int i = 0; i < int'(N); i++) m_hist[i] = 1'b0;
    m_waiting = 1'b0; m_deliver = 1'b0; m_hold = 1'b0;
    m_data = '0; m_led = '0;
  endtask

  task automatic model_update();
    logic [9:0] s_old;
    logic db_old, all_diff, idle, nx_wait, nx_del, nx_hold;
    if (reset) begin
      model_reset();
      return;
    end
    s_old  = m_s;
    db_old = m_db;
    for (int i = int'(N) - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = s_old[8];
    all_diff = 1'b1;
    for (int i = 0; i < int'(N); i++) if (m_hist[i] == db_old) all_diff = 1'b0;
    if (all_diff) m_db = ~db_old;
    m_s  = m_s1;
    m_s1 = sw;
    idle    = !(m_waiting || m_deliver || m_hold);
    nx_del  = m_waiting && rd_req && db_old;
    nx_hold = m_deliver || (m_hold && db_old);
    nx_wait = (idle && rd_req) || (m_waiting && rd_req && !db_old);
    if (nx_del) m_data = s_old[7:0];
    m_waiting = nx_wait;
    m_deliver = nx_del;
    m_hold    = nx_hold;
    if (wr_en) m_led = wr_data;
  endtask

  task automatic cmp_all();
    chk("model_rd_data", cpu_rd_data, m_data);
    chk("model_rd_valid", cpu_rd_valid, m_deliver);
    chk("model_stall", cpu_stall, rd_req & ~m_deliver);
    chk("model_run", cpu_run, m_s[9]);
    chk("model_led", led, m_led);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
    cmp_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_valid(input int max, output int lat, output int stall_cnt);
    lat = 0;
    stall_cnt = 0;
    for (int i = 1; i <= max; i++) begin
      cyc();
      if (cpu_rd_valid === 1'b1) begin
        lat = i;
        break;
      end
      if (cpu_stall === 1'b1) stall_cnt++;
    end
  endtask

  typedef struct {
    logic       rst;
    logic [9:0] sw;
    logic       req;
    logic       wr;
    logic [7:0] wd;
    logic [7:0] led;
    logic       run;
    logic       valid;
    logic       stall;
  } vec_t;

  vec_t tbl[8];
  int   lat, sc, nv, sw_hold;

  initial begin
    tbl[0] = '{1'b1, 10'h3FF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 10'h3FF, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 10'h3FF, 1'b0, 1'b1, 8'h81, 8'h81, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 10'h3FF, 1'b0, 1'b0, 8'h00, 8'h81, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 10'h000, 1'b0, 1'b1, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 10'h000, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 10'h000, 1'b1, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 10'h000, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; sw = '0; rd_req = 1'b0; wr_en = 1'b0; wr_data = '0;
    model_reset();

    for (int i = 0; i < 8; i++) begin
      reset = tbl[i].rst; sw = tbl[i].sw; rd_req = tbl[i].req;
      wr_en = tbl[i].wr;  wr_data = tbl[i].wd;
      cyc();
      chk("tbl_led", led, tbl[i].led);
      chk("tbl_run", cpu_run, tbl[i].run);
      chk("tbl_valid", cpu_rd_valid, tbl[i].valid);
      chk("tbl_stall", cpu_stall, tbl[i].stall);
      chk("tbl_rd_data", cpu_rd_data, 8'h00);
    end
    reset = 1'b0; rd_req = 1'b0; wr_en = 1'b0; sw = '0;
    idle_cycles(8);

    // Basic read of A5
    rd_req = 1'b1; sw = 10'h1A5;
    wait_valid(20, lat, sc);
    chk("basic_latency", lat, 7);
    chk("basic_data", cpu_rd_data, 8'hA5);
    chk("basic_stall_cycles", sc, 6);
    chk("basic_stall_at_valid", cpu_stall, 1'b0);
    rd_req = 1'b0;
    cyc();
    chk("basic_single_pulse", cpu_rd_valid, 1'b0);
    sw = 10'h0FF;
    idle_cycles(8);
    chk("basic_data_held", cpu_rd_data, 8'hA5);

    // 3-cycle glitch ignored, then an exactly 4-cycle press captured
    rd_req = 1'b1; nv = 0;
    for (int i = 0; i < 15; i++) begin
      sw = (i < 3) ? 10'h15A : 10'h05A;
      cyc();
      if (cpu_rd_valid === 1'b1) nv++;
    end
    chk("glitch_no_capture", nv, 0);
    chk("glitch_stall", cpu_stall, 1'b1);
    nv = 0; lat = 0;
    for (int i = 0; i < 15; i++) begin
      sw = (i < 4) ? 10'h15A : 10'h05A;
      cyc();
      if (cpu_rd_valid === 1'b1) begin
        nv++;
        if (lat == 0) lat = i + 1;
      end
    end
    chk("press4_count", nv, 1);
    chk("press4_latency", lat, 7);
    chk("press4_data", cpu_rd_data, 8'h5A);
    rd_req = 1'b0; sw = 10'h000;
    idle_cycles(3);

    // Second read while the strobe is still held
    rd_req = 1'b1; sw = 10'h1C3;
    wait_valid(20, lat, sc);
    chk("dbl_first_latency", lat, 7);
    chk("dbl_first_data", cpu_rd_data, 8'hC3);
    rd_req = 1'b0;
    cyc();
    rd_req = 1'b1; nv = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (cpu_rd_valid === 1'b1) nv++;
    end
    chk("dbl_held_no_valid", nv, 0);
    chk("dbl_held_stall", cpu_stall, 1'b1);
    sw = 10'h03C; nv = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (cpu_rd_valid === 1'b1) nv++;
    end
    chk("dbl_release_no_valid", nv, 0);
    sw = 10'h13C;
    wait_valid(20, lat, sc);
    chk("dbl_second_latency", lat, 7);
    chk("dbl_second_data", cpu_rd_data, 8'h3C);
    rd_req = 1'b0; sw = 10'h03C;
    idle_cycles(8);

    // Write alongside a read
    rd_req = 1'b1; wr_en = 1'b1; wr_data = 8'h81; sw = 10'h111;
    cyc();
    wr_en = 1'b0;
    chk("wr_led_81", led, 8'h81);
    wait_valid(20, lat, sc);
    chk("wr_read_latency", lat, 6);
    chk("wr_read_data", cpu_rd_data, 8'h11);
    wr_en = 1'b1; wr_data = 8'h42; rd_req = 1'b0;
    cyc();
    wr_en = 1'b0;
    chk("wr_led_42", led, 8'h42);
    sw = 10'h011;
    idle_cycles(8);

    // Reset while waiting for a press
    wr_en = 1'b1; wr_data = 8'h99; rd_req = 1'b1; sw = 10'h000;
    cyc();
    wr_en = 1'b0;
    idle_cycles(2);
    reset = 1'b1; rd_req = 1'b0;
    cyc();
    reset = 1'b0;
    chk("rst_mid_led", led, 8'h00);
    chk("rst_mid_valid", cpu_rd_valid, 1'b0);
    chk("rst_mid_data", cpu_rd_data, 8'h00);
    sw = 10'h100; nv = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (cpu_rd_valid === 1'b1) nv++;
    end
    chk("rst_mid_no_valid", nv, 0);
    rd_req = 1'b1;
    wait_valid(10, lat, sc);
    chk("min_latency", lat, 2);
    rd_req = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0; rd_req = 1'b1;
    wait_valid(20, lat, sc);
    chk("held_through_reset_latency", lat, 7);
    rd_req = 1'b0; sw = 10'h000;
    idle_cycles(8);

    // Randomized run against the model
    reset = 1'b1;
    cyc();
    reset = 1'b0; sw_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rd_req && m_deliver) rd_req = 1'b0;
      else if (!rd_req && $urandom_range(0, 5) == 0) rd_req = 1'b1;
      else if (rd_req && $urandom_range(0, 60) == 0) rd_req = 1'b0;
      if (sw_hold == 0) begin
        sw[8]   = ~sw[8];
        sw_hold = $urandom_range(1, 10);
      end else begin
        sw_hold--;
      end
      if ($urandom_range(0, 2) == 0) sw[7:0] = 8'($urandom);
      if ($urandom_range(0, 30) == 0) sw[9] = ~sw[9];
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_data = 8'($urandom);
      reset   = ($urandom_range(0, 400) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
